// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared definitions for the data-memory load/store unit:
//     - access size codes carried on DATA_MEM_In
//     - response error codes carried on err_code
//     - lane_mask(): byte-lane write enables for a store of a given size/offset
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [2:0] SZ_BS = 3'b001;   // byte, sign-extended
    localparam logic [2:0] SZ_HS = 3'b010;   // half, sign-extended
    localparam logic [2:0] SZ_W  = 3'b011;   // 32-bit word
    localparam logic [2:0] SZ_BU = 3'b101;   // byte, zero-extended
    localparam logic [2:0] SZ_HU = 3'b110;   // half, zero-extended

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_SIZE     = 2'b11;

    // Widest lane mask supported (DATA_W up to 512 bits); callers cast down.
    localparam int MAX_LANES = 64;
    localparam int OFF_W_MAX = 6;

    function automatic logic [MAX_LANES-1:0] lane_mask(input logic [2:0]           size,
                                                       input logic [OFF_W_MAX-1:0] off);
        logic [MAX_LANES-1:0] m;
        m = '0;
        case (size)
            SZ_BS, SZ_BU: m = MAX_LANES'(1)  << off;
            SZ_HS, SZ_HU: m = MAX_LANES'(3)  << off;
            SZ_W:         m = MAX_LANES'(15);        // word stores are always lane 0..3
            default:      m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// -----------------------------------------------------------------------------
// dmem_load_align
//   Combinational load formatter: picks the addressed byte/half/word out of a
//   memory word and sign- or zero-extends it to DATA_W.
//   Ports:
//     word   in  DATA_W  raw memory word
//     offset in  OFF_W   byte offset inside the word
//     size   in  3       size code (SZ_*)
//     data   out DATA_W  extended load value (0 for unknown size codes)
// -----------------------------------------------------------------------------
module dmem_load_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] word,
    input  logic [OFF_W-1:0]  offset,
    input  logic [2:0]        size,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        // Bring the addressed byte down to bit 0 before extending.
        shifted = word >> {offset, 3'b000};
        case (size)
            SZ_BS:   data = DATA_W'($signed(shifted[7:0]));
            SZ_BU:   data = DATA_W'(shifted[7:0]);
            SZ_HS:   data = DATA_W'($signed(shifted[15:0]));
            SZ_HU:   data = DATA_W'(shifted[15:0]);
            SZ_W:    data = DATA_W'($signed(shifted[31:0]));
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
//   Byte-addressed data memory with a load/store front end for the MEM stage.
//   One request per cycle; stores write byte lanes at the accept edge; loads
//   and faulted accesses return through an RD_LAT-deep response pipeline.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     req_valid / req_ready      request handshake (ready = out of reset)
//     mem_read / mem_write       load / store (load wins if both set)
//     DATA_MEM_In                size code
//     addr, write_data           byte address, store data
//     resp_valid                 one-cycle response pulse
//     read_data                  extended load data (held when idle)
//     resp_err, err_code         fault flag and reason, zero when idle
// -----------------------------------------------------------------------------
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        DATA_MEM_In,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    output logic              resp_valid,
    output logic [DATA_W-1:0] read_data,
    output logic              resp_err,
    output logic [1:0]        err_code
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(DEPTH * NB);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept, is_store;
    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        code;
    logic              fault;
    logic [NB-1:0]     wmask;
    logic [DATA_W-1:0] wbytes;
    logic [DATA_W-1:0] ld_data;

    logic              in_vld, in_err;
    logic [1:0]        in_code;
    logic [DATA_W-1:0] in_data;

    logic [RD_LAT-1:0]             vld_q,  vld_d;
    logic [RD_LAT-1:0]             err_q,  err_d;
    logic [RD_LAT-1:0][1:0]        code_q, code_d;
    logic [RD_LAT-1:0][DATA_W-1:0] data_q, data_d;

    assign req_ready = rst_n;
    assign accept    = req_valid & req_ready & (mem_read | mem_write);
    assign is_store  = mem_write & ~mem_read;
    assign off       = addr[OFF_W-1:0];
    assign idx       = addr[IDX_W+OFF_W-1:OFF_W];

    // Fault classification; earlier checks mask later ones.
    always_comb begin
        code = ERR_NONE;
        if ((DATA_MEM_In == 3'b000) || (DATA_MEM_In == 3'b100) || (DATA_MEM_In == 3'b111) ||
            (is_store && ((DATA_MEM_In == SZ_BU) || (DATA_MEM_In == SZ_HU)))) begin
            code = ERR_SIZE;
        end else if ({1'b0, addr} >= MEM_BYTES) begin
            code = ERR_RANGE;
        end else if (((DATA_MEM_In == SZ_HS) || (DATA_MEM_In == SZ_HU)) && off[0]) begin
            code = ERR_MISALIGN;
        end else if ((DATA_MEM_In == SZ_W) && (off != '0)) begin
            code = ERR_MISALIGN;
        end
    end

    assign fault  = (code != ERR_NONE);
    assign wmask  = NB'(lane_mask(DATA_MEM_In, OFF_W_MAX'(off)));
    // Source bytes are placed at the target lane so the mask alone selects them.
    assign wbytes = DATA_W'(write_data[31:0]) << {off, 3'b000};

    always_ff @(posedge clk) begin
        if (accept && is_store && !fault) begin
            for (int b = 0; b < NB; b++) begin
                if (wmask[b]) mem_q[idx][b*8 +: 8] <= wbytes[b*8 +: 8];
            end
        end
    end

    dmem_load_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_align (
        .word   (mem_q[idx]),
        .offset (off),
        .size   (DATA_MEM_In),
        .data   (ld_data)
    );

    // Loads always respond; stores respond only when faulted.
    assign in_vld  = accept & (mem_read | fault);
    assign in_err  = accept & fault;
    assign in_code = accept ? code : ERR_NONE;
    assign in_data = (mem_read && !fault) ? ld_data : '0;

    // Response shift pipeline; data only moves with a valid entry so the
    // last stage holds the previous result while idle.
    always_comb begin
        vld_d[0]  = in_vld;
        err_d[0]  = in_err;
        code_d[0] = in_code;
        data_d[0] = in_vld ? in_data : data_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            err_d[i]  = err_q[i-1];
            code_d[i] = code_q[i-1];
            data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            err_q  <= '0;
            code_q <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            err_q  <= err_d;
            code_q <= code_d;
            data_q <= data_d;
        end
    end

    assign resp_valid = vld_q[RD_LAT-1];
    assign resp_err   = err_q[RD_LAT-1];
    assign err_code   = code_q[RD_LAT-1];
    assign read_data  = data_q[RD_LAT-1];

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu
//   Directed, table-driven bench for dmem_lsu (RD_LAT = 3) plus hand-written
//   sequences for back-to-back throughput, idle hold and reset mid-flight.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        resp_valid;
    logic [31:0] read_data;
    logic        resp_err;
    logic [1:0]  err_code;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_lsu #(
        .DATA_W (32),
        .DEPTH  (64),
        .RD_LAT (LAT),
        .ADDR_W (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .DATA_MEM_In (size),
        .addr        (addr),
        .write_data  (write_data),
        .resp_valid  (resp_valid),
        .read_data   (read_data),
        .resp_err    (resp_err),
        .err_code    (err_code)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_v;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got %h, expected %h", nm, id, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic ev, input logic ee, input logic [1:0] ec,
                       input logic [31:0] ed);
        vec_t v;
        v.rd = rd; v.wr = wr; v.sz = sz; v.addr = a; v.wdata = wd;
        v.exp_v = ev; v.exp_err = ee; v.exp_code = ec; v.exp_data = ed;
        vecs.push_back(v);
    endtask

    task automatic drive_req(input logic rd, input logic wr, input logic [2:0] sz,
                             input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; mem_read = rd; mem_write = wr; size = sz; addr = a; write_data = wd;
    endtask

    task automatic drive_idle();
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        size = 3'b000; addr = '0; write_data = '0;
    endtask

    // One request, then watch exactly LAT sample points after the accept edge.
    task automatic run_vec(input vec_t v, input int id);
        logic early;
        early = 1'b0;
        @(negedge clk);
        drive_req(v.rd, v.wr, v.sz, v.addr, v.wdata);
        for (int j = 0; j < LAT; j++) begin
            @(negedge clk);
            if (j == 0) drive_idle();
            if (j < LAT - 1) early = early | resp_valid;
        end
        check("resp_valid_timing", id, {31'b0, resp_valid & ~early}, {31'b0, v.exp_v});
        if (v.exp_v) begin
            check("resp_err", id, {31'b0, resp_err}, {31'b0, v.exp_err});
            check("err_code", id, {30'b0, err_code}, {30'b0, v.exp_code});
            if (v.rd) check("read_data", id, read_data, v.exp_data);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        seen_v [12];
        logic [31:0] seen_d [12];
        logic        any_v;

        rst_n = 1'b1;
        drive_idle();
        #3 rst_n = 1'b0;
        #1;
        check("rst_resp_valid", 0, {31'b0, resp_valid}, 32'd0);
        check("rst_read_data",  0, read_data, 32'd0);
        check("rst_resp_err",   0, {31'b0, resp_err}, 32'd0);
        check("rst_err_code",   0, {30'b0, err_code}, 32'd0);
        check("rst_req_ready",  0, {31'b0, req_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("req_ready_after_rst", 0, {31'b0, req_ready}, 32'd1);

        //   rd  wr  size    addr       wdata         v  err code data
        add(0, 1, 3'b011, 32'h10,  32'hDEADBEEF, 0, 0, 2'b00, 32'h0);
        add(1, 0, 3'b011, 32'h10,  32'h0,        1, 0, 2'b00, 32'hDEADBEEF);
        add(0, 1, 3'b011, 32'h20,  32'h0,        0, 0, 2'b00, 32'h0);
        add(0, 1, 3'b001, 32'h22,  32'h12345680, 0, 0, 2'b00, 32'h0);
        add(1, 0, 3'b011, 32'h20,  32'h0,        1, 0, 2'b00, 32'h00800000);
        add(1, 0, 3'b001, 32'h22,  32'h0,        1, 0, 2'b00, 32'hFFFFFF80);
        add(1, 0, 3'b101, 32'h22,  32'h0,        1, 0, 2'b00, 32'h00000080);
        add(0, 1, 3'b011, 32'h30,  32'h11223344, 0, 0, 2'b00, 32'h0);
        add(0, 1, 3'b010, 32'h32,  32'hABCD8001, 0, 0, 2'b00, 32'h0);
        add(1, 0, 3'b010, 32'h32,  32'h0,        1, 0, 2'b00, 32'hFFFF8001);
        add(1, 0, 3'b110, 32'h32,  32'h0,        1, 0, 2'b00, 32'h00008001);
        add(1, 0, 3'b011, 32'h30,  32'h0,        1, 0, 2'b00, 32'h80013344);
        add(1, 0, 3'b101, 32'h31,  32'h0,        1, 0, 2'b00, 32'h00000033);
        add(0, 1, 3'b011, 32'h00,  32'hA5A5A5A5, 0, 0, 2'b00, 32'h0);
        add(1, 0, 3'b011, 32'h21,  32'h0,        1, 1, 2'b01, 32'h0);
        add(0, 1, 3'b010, 32'h101, 32'hFFFFFFFF, 1, 1, 2'b10, 32'h0);
        add(1, 0, 3'b011, 32'h00,  32'h0,        1, 0, 2'b00, 32'hA5A5A5A5);
        add(1, 0, 3'b011, 32'h100, 32'h0,        1, 1, 2'b10, 32'h0);
        add(1, 0, 3'b100, 32'h10,  32'h0,        1, 1, 2'b11, 32'h0);
        add(0, 1, 3'b101, 32'h10,  32'h0,        1, 1, 2'b11, 32'h0);
        add(1, 0, 3'b110, 32'h33,  32'h0,        1, 1, 2'b01, 32'h0);
        add(1, 0, 3'b000, 32'h10,  32'h0,        1, 1, 2'b11, 32'h0);
        add(0, 1, 3'b111, 32'h10,  32'h0,        1, 1, 2'b11, 32'h0);
        add(0, 1, 3'b110, 32'h41,  32'h0,        1, 1, 2'b11, 32'h0);
        add(1, 0, 3'b111, 32'h200, 32'h0,        1, 1, 2'b11, 32'h0);
        add(1, 1, 3'b011, 32'h10,  32'h0,        1, 0, 2'b00, 32'hDEADBEEF);
        add(1, 0, 3'b011, 32'h10,  32'h0,        1, 0, 2'b00, 32'hDEADBEEF);
        add(1, 0, 3'b001, 32'h13,  32'h0,        1, 0, 2'b00, 32'hFFFFFFDE);
        add(0, 1, 3'b011, 32'h04,  32'h44444444, 0, 0, 2'b00, 32'h0);
        add(0, 1, 3'b011, 32'h08,  32'h88888888, 0, 0, 2'b00, 32'h0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i + 1);

        // Back-to-back loads: responses on consecutive cycles, in order.
        @(negedge clk);
        drive_req(1'b1, 1'b0, 3'b011, 32'h00, 32'h0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) drive_req(1'b1, 1'b0, 3'b011, 32'h04, 32'h0);
            if (c == 1) drive_req(1'b1, 1'b0, 3'b011, 32'h08, 32'h0);
            if (c == 2) drive_idle();
            seen_v[c] = resp_valid;
            seen_d[c] = read_data;
        end
        check("b2b_valid0", 100, {31'b0, seen_v[LAT-1]}, 32'd1);
        check("b2b_data0",  100, seen_d[LAT-1], 32'hA5A5A5A5);
        check("b2b_valid1", 101, {31'b0, seen_v[LAT]}, 32'd1);
        check("b2b_data1",  101, seen_d[LAT], 32'h44444444);
        check("b2b_valid2", 102, {31'b0, seen_v[LAT+1]}, 32'd1);
        check("b2b_data2",  102, seen_d[LAT+1], 32'h88888888);
        any_v = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c < LAT - 1 || c > LAT + 1) any_v = any_v | seen_v[c];
        end
        check("b2b_no_extra", 103, {31'b0, any_v}, 32'd0);

        // Idle: data held, error fields cleared.
        check("idle_read_data",  104, read_data, 32'h88888888);
        check("idle_resp_valid", 104, {31'b0, resp_valid}, 32'd0);
        check("idle_resp_err",   104, {31'b0, resp_err}, 32'd0);
        check("idle_err_code",   104, {30'b0, err_code}, 32'd0);

        // Reset with two loads in flight.
        @(negedge clk);
        drive_req(1'b1, 1'b0, 3'b011, 32'h04, 32'h0);
        @(negedge clk);
        drive_req(1'b1, 1'b0, 3'b011, 32'h08, 32'h0);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #1;
        check("midrst_resp_valid", 105, {31'b0, resp_valid}, 32'd0);
        check("midrst_read_data",  105, read_data, 32'd0);
        check("midrst_resp_err",   105, {31'b0, resp_err}, 32'd0);
        check("midrst_err_code",   105, {30'b0, err_code}, 32'd0);
        check("midrst_req_ready",  105, {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        any_v = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            any_v = any_v | resp_valid;
        end
        check("midrst_no_resp", 106, {31'b0, any_v}, 32'd0);

        // Pipeline works again after reset.
        begin
            vec_t v;
            v.rd = 0; v.wr = 1; v.sz = 3'b011; v.addr = 32'h3C; v.wdata = 32'h5A5A5A5A;
            v.exp_v = 0; v.exp_err = 0; v.exp_code = 2'b00; v.exp_data = 32'h0;
            run_vec(v, 107);
            v.rd = 1; v.wr = 0; v.wdata = 32'h0; v.exp_v = 1; v.exp_data = 32'h5A5A5A5A;
            run_vec(v, 108);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
